// File: rtl/pshpul_seq_pkg.sv
// Shared register codes, postbyte bit positions and state encodings for the
// 6809 push/pull sequencer.
package pshpul_seq_pkg;

    localparam logic [3:0] RN_D  = 4'd0;
    localparam logic [3:0] RN_X  = 4'd1;
    localparam logic [3:0] RN_Y  = 4'd2;
    localparam logic [3:0] RN_U  = 4'd3;
    localparam logic [3:0] RN_S  = 4'd4;
    localparam logic [3:0] RN_PC = 4'd5;
    localparam logic [3:0] RN_A  = 4'd8;
    localparam logic [3:0] RN_B  = 4'd9;
    localparam logic [3:0] RN_CC = 4'd10;
    localparam logic [3:0] RN_DP = 4'd11;

    localparam int unsigned PSH_CC = 0;
    localparam int unsigned PSH_A  = 1;
    localparam int unsigned PSH_B  = 2;
    localparam int unsigned PSH_DP = 3;
    localparam int unsigned PSH_X  = 4;
    localparam int unsigned PSH_Y  = 5;
    localparam int unsigned PSH_US = 6;
    localparam int unsigned PSH_PC = 7;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/pshpul_pick.sv
// Picks the next postbyte item: highest remaining bit on push, lowest on pull,
// and maps it to a register code and width.
module pshpul_pick
    import pshpul_seq_pkg::*;
(
    input  logic [7:0] mask,
    input  logic       is_pull,
    input  logic       use_s,
    output logic [2:0] idx,
    output logic [3:0] code,
    output logic       is16,
    output logic       last
);

    // Later loop iterations win: ascending scan finds highest, descending finds lowest.
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (is_pull) begin
                if (mask[7 - i]) idx = 3'(7 - i);
            end else if (mask[i]) begin
                idx = 3'(i);
            end
        end
    end

    always_comb begin
        code = RN_CC;
        case (idx)
            3'(PSH_PC): code = RN_PC;
            3'(PSH_US): code = use_s ? RN_U : RN_S;
            3'(PSH_Y):  code = RN_Y;
            3'(PSH_X):  code = RN_X;
            3'(PSH_DP): code = RN_DP;
            3'(PSH_B):  code = RN_B;
            3'(PSH_A):  code = RN_A;
            default:    code = RN_CC;
        endcase
    end

    assign is16 = (idx >= 3'(PSH_X));
    assign last = ((mask & ~(8'(1) << idx)) == 8'h00);

endmodule

// File: rtl/pshpul_seq.sv
// PSHS/PSHU/PULS/PULU byte sequencer sitting in front of the register block;
// one memory byte per cycle, request/strobe outputs qualified by mem_ready.
module pshpul_seq
    import pshpul_seq_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start,
    input  logic        is_pull,
    input  logic        use_s_in,
    input  logic [7:0]  mask,
    input  logic [15:0] reg_su,
    input  logic [15:0] path_left_data,
    input  logic [7:0]  mem_data_i,
    input  logic        mem_ready,
    output logic        use_s,
    output logic [3:0]  path_left_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data_o,
    output logic        dec_su,
    output logic        inc_su,
    output logic        write_reg,
    output logic [3:0]  write_reg_addr,
    output logic [15:0] data_w,
    output logic        busy,
    output logic        done
);

    logic [0:0] state, state_n;
    logic [7:0] mask_r, mask_n;
    logic [7:0] hi_r, hi_n;
    logic       pull_r, pull_n;
    logic       use_s_n;
    logic       phase_r, phase_n;
    logic       done_n;

    logic [2:0] sel_idx;
    logic [3:0] sel_code;
    logic       sel_is16;
    logic       sel_last;
    logic       run;
    logic       final_byte;

    pshpul_pick u_pick (
        .mask    (mask_r),
        .is_pull (pull_r),
        .use_s   (use_s),
        .idx     (sel_idx),
        .code    (sel_code),
        .is16    (sel_is16),
        .last    (sel_last)
    );

    assign run        = (state == ST_RUN);
    assign final_byte = ~sel_is16 | phase_r;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= ST_IDLE;
            mask_r  <= 8'h00;
            hi_r    <= 8'h00;
            pull_r  <= 1'b0;
            use_s   <= 1'b0;
            phase_r <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            mask_r  <= mask_n;
            hi_r    <= hi_n;
            pull_r  <= pull_n;
            use_s   <= use_s_n;
            phase_r <= phase_n;
            done    <= done_n;
        end
    end

    // A mask bit retires only when its last byte is accepted.
    always_comb begin
        state_n = state;
        mask_n  = mask_r;
        hi_n    = hi_r;
        pull_n  = pull_r;
        use_s_n = use_s;
        phase_n = phase_r;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (mask != 8'h00) begin
                        state_n = ST_RUN;
                        mask_n  = mask;
                        pull_n  = is_pull;
                        use_s_n = use_s_in;
                        phase_n = 1'b0;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (mem_ready) begin
                    if (final_byte) begin
                        mask_n  = mask_r & ~(8'(1) << sel_idx);
                        phase_n = 1'b0;
                        if (sel_last) begin
                            state_n = ST_IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        phase_n = 1'b1;
                        if (pull_r) hi_n = mem_data_i;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Push sends low byte first; pull receives high byte first.
    always_comb begin
        busy           = run;
        mem_req        = run;
        mem_we         = run & ~pull_r;
        mem_addr       = 16'h0000;
        mem_data_o     = 8'h00;
        path_left_addr = 4'h0;
        dec_su         = 1'b0;
        inc_su         = 1'b0;
        write_reg      = 1'b0;
        write_reg_addr = 4'h0;
        data_w         = 16'h0000;
        if (run) begin
            if (pull_r) begin
                mem_addr = reg_su;
                inc_su   = mem_ready;
                if (mem_ready && final_byte) begin
                    write_reg      = 1'b1;
                    write_reg_addr = sel_code;
                    data_w         = sel_is16 ? {hi_r, mem_data_i} : {8'h00, mem_data_i};
                end
            end else begin
                mem_addr       = reg_su - 16'd1;
                path_left_addr = sel_code;
                mem_data_o     = phase_r ? path_left_data[15:8] : path_left_data[7:0];
                dec_su         = mem_ready;
            end
        end
    end

endmodule

// File: tb/tb_pshpul_seq.sv
// Directed bench for pshpul_seq with a register-block/memory model and
// scoreboard queues for memory transfers and register writes.
module tb_pshpul_seq;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } mem_t;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start;
    logic        is_pull;
    logic        use_s_in;
    logic [7:0]  mask;
    logic [15:0] reg_su;
    logic [15:0] path_left_data;
    logic [7:0]  mem_data_i;
    logic        mem_ready;
    logic        use_s;
    logic [3:0]  path_left_addr;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_o;
    logic        dec_su;
    logic        inc_su;
    logic        write_reg;
    logic [3:0]  write_reg_addr;
    logic [15:0] data_w;
    logic        busy;
    logic        done;

    logic [7:0]  mem  [0:65535];
    logic [15:0] regs [0:15];
    mem_t        exp_mem[$];
    wr_t         exp_wr[$];
    mem_t        em;
    wr_t         ew;

    int nchk  = 0;
    int npass = 0;
    int nfail = 0;
    int n_dec = 0;
    int n_inc = 0;

    always #5 clk_in = ~clk_in;

    pshpul_seq dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .start          (start),
        .is_pull        (is_pull),
        .use_s_in       (use_s_in),
        .mask           (mask),
        .reg_su         (reg_su),
        .path_left_data (path_left_data),
        .mem_data_i     (mem_data_i),
        .mem_ready      (mem_ready),
        .use_s          (use_s),
        .path_left_addr (path_left_addr),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_data_o     (mem_data_o),
        .dec_su         (dec_su),
        .inc_su         (inc_su),
        .write_reg      (write_reg),
        .write_reg_addr (write_reg_addr),
        .data_w         (data_w),
        .busy           (busy),
        .done           (done)
    );

    assign reg_su         = use_s ? regs[4] : regs[3];
    assign path_left_data = regs[path_left_addr];
    assign mem_data_i     = mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register block and memory model.
    always @(posedge clk_in) begin
        if (mem_req && mem_ready && mem_we) mem[mem_addr] <= mem_data_o;
        if (write_reg) regs[write_reg_addr] <= data_w;
        if (dec_su) regs[use_s ? 4'd4 : 4'd3] <= reg_su - 16'd1;
        if (inc_su) regs[use_s ? 4'd4 : 4'd3] <= reg_su + 16'd1;
    end

    // Scoreboard side: pop and compare every accepted transfer and register write.
    always @(negedge clk_in) begin
        if (dec_su) n_dec++;
        if (inc_su) n_inc++;
        if (mem_req && mem_ready) begin
            if (exp_mem.size() == 0) begin
                check("xfer_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                em = exp_mem.pop_front();
                check("xfer_we", 32'(mem_we), 32'(em.we));
                check("xfer_addr", 32'(mem_addr), 32'(em.addr));
                if (em.we) check("xfer_data", 32'(mem_data_o), 32'(em.data));
            end
        end
        if (write_reg) begin
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", 32'(write_reg_addr), 32'hFFFF_FFFF);
            end else begin
                ew = exp_wr.pop_front();
                check("wr_addr", 32'(write_reg_addr), 32'(ew.addr));
                check("wr_data", 32'(data_w), 32'(ew.data));
            end
        end
    end

    task automatic push_mem(input logic we, input logic [15:0] addr, input logic [7:0] data);
        mem_t m;
        m.we = we; m.addr = addr; m.data = data;
        exp_mem.push_back(m);
    endtask

    task automatic push_wr(input logic [3:0] addr, input logic [15:0] data);
        wr_t w;
        w.addr = addr; w.data = data;
        exp_wr.push_back(w);
    endtask

    // Issue one start and follow the sequence to done; optional stall window
    // and a stray start at cycle 2 that must be ignored while busy.
    task automatic run_seq(input logic pull, input logic us, input logic [7:0] mk,
                           input int stall_at, input int stall_len,
                           input logic [15:0] stall_addr, input int exp_lat, input string tag);
        int cyc;
        int lat;
        lat = -1;
        @(posedge clk_in); #1;
        start = 1'b1; is_pull = pull; use_s_in = us; mask = mk; mem_ready = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0; mask = 8'h00;
        cyc = 1;
        while (cyc < 60) begin
            mem_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            start = (cyc == 2) && (exp_lat > 2);
            is_pull = ~pull; mask = start ? 8'hFF : 8'h00;
            @(negedge clk_in);
            if (done) begin
                lat = cyc;
                break;
            end
            if (!mem_ready)
                check({tag, "_stall_hold"}, 32'({mem_req, mem_we, inc_su, dec_su, write_reg, mem_addr}),
                      32'({5'b10000, stall_addr}));
            @(posedge clk_in); #1;
            cyc++;
        end
        start = 1'b0; mask = 8'h00; mem_ready = 1'b1;
        check({tag, "_done_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk_in);
        check({tag, "_done_single"}, 32'({done, busy}), 32'd0);
    endtask

    initial begin
        rst_in = 1'b1; start = 1'b0; is_pull = 1'b0; use_s_in = 1'b0;
        mask = 8'h00; mem_ready = 1'b1;
        for (int i = 0; i < 16; i++) regs[i] = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("reset_ctrl", 32'({busy, done, mem_req, mem_we, dec_su, inc_su, write_reg, use_s,
                                 path_left_addr, write_reg_addr}), 32'd0);
        check("reset_data", 32'({mem_addr, mem_data_o}), 32'd0);
        check("reset_dataw", 32'(data_w), 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // 1: PSHS A,B
        regs[4] = 16'h0F00; regs[8] = 16'h0012; regs[9] = 16'h0034; n_dec = 0;
        push_mem(1'b1, 16'h0EFF, 8'h34);
        push_mem(1'b1, 16'h0EFE, 8'h12);
        run_seq(1'b0, 1'b1, 8'h06, 99, 0, 16'h0000, 3, "t1");
        check("t1_dec_count", 32'(n_dec), 32'd2);
        check("t1_s_final", 32'(regs[4]), 32'h0EFE);
        check("t1_mem_b", 32'(mem[16'h0EFF]), 32'h34);

        // 2: PULS PC
        regs[4] = 16'h0F00; mem[16'h0F00] = 8'hAB; mem[16'h0F01] = 8'hCD; n_inc = 0;
        push_mem(1'b0, 16'h0F00, 8'h00);
        push_mem(1'b0, 16'h0F01, 8'h00);
        push_wr(4'd5, 16'hABCD);
        run_seq(1'b1, 1'b1, 8'h80, 99, 0, 16'h0000, 3, "t2");
        check("t2_inc_count", 32'(n_inc), 32'd2);
        check("t2_s_final", 32'(regs[4]), 32'h0F02);
        check("t2_pc", 32'(regs[5]), 32'hABCD);

        // 3: PSHU all
        regs[3] = 16'h0E00; regs[5] = 16'h1234; regs[4] = 16'h5678; regs[2] = 16'h9ABC;
        regs[1] = 16'hDEF0; regs[11] = 16'h0011; regs[9] = 16'h0022; regs[8] = 16'h0033;
        regs[10] = 16'h0044; n_dec = 0;
        push_mem(1'b1, 16'h0DFF, 8'h34); push_mem(1'b1, 16'h0DFE, 8'h12);
        push_mem(1'b1, 16'h0DFD, 8'h78); push_mem(1'b1, 16'h0DFC, 8'h56);
        push_mem(1'b1, 16'h0DFB, 8'hBC); push_mem(1'b1, 16'h0DFA, 8'h9A);
        push_mem(1'b1, 16'h0DF9, 8'hF0); push_mem(1'b1, 16'h0DF8, 8'hDE);
        push_mem(1'b1, 16'h0DF7, 8'h11); push_mem(1'b1, 16'h0DF6, 8'h22);
        push_mem(1'b1, 16'h0DF5, 8'h33); push_mem(1'b1, 16'h0DF4, 8'h44);
        run_seq(1'b0, 1'b0, 8'hFF, 99, 0, 16'h0000, 13, "t3");
        check("t3_dec_count", 32'(n_dec), 32'd12);
        check("t3_u_final", 32'(regs[3]), 32'h0DF4);
        check("t3_mem_cc", 32'(mem[16'h0DF4]), 32'h44);

        // 4: empty mask
        regs[4] = 16'h0F00; n_dec = 0; n_inc = 0;
        run_seq(1'b0, 1'b1, 8'h00, 99, 0, 16'h0000, 1, "t4");
        check("t4_su_change", 32'({regs[4], 8'(n_dec), 8'(n_inc)}), 32'h0F00_0000);

        // 5: PULS CC,X with stall on X high byte
        regs[4] = 16'h0F00; mem[16'h0F00] = 8'h55; mem[16'h0F01] = 8'hAA; mem[16'h0F02] = 8'hBB;
        n_inc = 0;
        push_mem(1'b0, 16'h0F00, 8'h00);
        push_mem(1'b0, 16'h0F01, 8'h00);
        push_mem(1'b0, 16'h0F02, 8'h00);
        push_wr(4'd10, 16'h0055);
        push_wr(4'd1, 16'hAABB);
        run_seq(1'b1, 1'b1, 8'h11, 2, 3, 16'h0F01, 7, "t5");
        check("t5_inc_count", 32'(n_inc), 32'd3);
        check("t5_x", 32'(regs[1]), 32'hAABB);
        check("t5_cc", 32'(regs[10]), 32'h0055);

        // 6: reset after first byte of a 16-bit pull
        regs[4] = 16'h0F00; regs[1] = 16'h1111; mem[16'h0F00] = 8'h77; n_inc = 0;
        push_mem(1'b0, 16'h0F00, 8'h00);
        @(posedge clk_in); #1;
        start = 1'b1; is_pull = 1'b1; use_s_in = 1'b1; mask = 8'h10;
        @(posedge clk_in); #1;
        start = 1'b0; mask = 8'h00;
        @(posedge clk_in); #1;
        rst_in = 1'b1; mem_ready = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0; mem_ready = 1'b1;
        @(negedge clk_in);
        check("t6_after_reset", 32'({busy, mem_req, write_reg, inc_su}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("t6_no_done", 32'(done), 32'd0);
            @(negedge clk_in);
        end
        check("t6_x_kept", 32'(regs[1]), 32'h1111);
        check("t6_s_final", 32'({regs[4], 8'(n_inc)}), 32'h0F01_01);

        mem[16'h0F01] = 8'h9A; mem[16'h0F02] = 8'hBC;
        push_mem(1'b0, 16'h0F01, 8'h00);
        push_mem(1'b0, 16'h0F02, 8'h00);
        push_wr(4'd5, 16'h9ABC);
        run_seq(1'b1, 1'b1, 8'h80, 99, 0, 16'h0000, 3, "t6b");
        check("t6b_pc", 32'(regs[5]), 32'h9ABC);

        check("sb_mem_empty", 32'(exp_mem.size()), 32'd0);
        check("sb_wr_empty", 32'(exp_wr.size()), 32'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
